// File: rtl/loader_pkg.sv
// ============================================================================
// loader_pkg : shared state encoding and width constants for program_loader
// Revision   : 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 16;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_CNT_HI  = 3'd0,
    ST_CNT_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_WRITE   = 3'd4,
    ST_CHK     = 3'd5,
    ST_RUN     = 3'd6,
    ST_ERR     = 3'd7
  } state_e;

endpackage

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// program_loader : boot-time byte-stream loader into instruction memory with
//                  XOR checksum; releases the core on a good load.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module program_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              strt,
  output logic              done,
  output logic              err
);

  state_e              state_q;
  logic [BYTE_W-1:0]   hi_q;
  logic [WORD_W-1:0]   cnt_q;
  logic [BYTE_W-1:0]   acc_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                we_q;
  logic                core_rst_q;
  logic                strt_q;
  logic                done_q;
  logic                err_q;
  logic                accept;

  assign in_ready = !rst && (state_q inside {ST_CNT_HI, ST_CNT_LO, ST_DATA_HI,
                                             ST_DATA_LO, ST_CHK});
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CNT_HI;
      hi_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      core_rst_q <= 1'b1;
      strt_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_CNT_HI: if (accept) begin
          cnt_q[WORD_W-1:BYTE_W] <= in_byte;
          state_q                <= ST_CNT_LO;
        end
        ST_CNT_LO: if (accept) begin
          cnt_q[BYTE_W-1:0] <= in_byte;
          state_q <= ({cnt_q[WORD_W-1:BYTE_W], in_byte} == '0) ? ST_CHK : ST_DATA_HI;
        end
        ST_DATA_HI: if (accept) begin
          hi_q    <= in_byte;
          acc_q   <= acc_q ^ in_byte;
          state_q <= ST_DATA_LO;
        end
        // Strobe is launched here so it is high exactly during WRITE.
        ST_DATA_LO: if (accept) begin
          wdata_q <= {hi_q, in_byte};
          acc_q   <= acc_q ^ in_byte;
          we_q    <= 1'b1;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          addr_q  <= addr_q + ADDR_W'(1);
          cnt_q   <= cnt_q - WORD_W'(1);
          state_q <= (cnt_q == WORD_W'(1)) ? ST_CHK : ST_DATA_HI;
        end
        ST_CHK: if (accept) begin
          if (in_byte == acc_q) begin
            core_rst_q <= 1'b0;
            strt_q     <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= ST_RUN;
          end else begin
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end
        end
        ST_RUN, ST_ERR: if (reload) begin
          acc_q      <= '0;
          cnt_q      <= '0;
          addr_q     <= BASE_ADDR;
          core_rst_q <= 1'b1;
          strt_q     <= 1'b0;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          state_q    <= ST_CNT_HI;
        end
        default: state_q <= ST_CNT_HI;
      endcase
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign core_rst  = core_rst_q;
  assign strt      = strt_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

`default_nettype wire
